hex_record_emitter: RTL and testbench
=====================================

Name: hex_record_emitter

Overview:
Reads a region of the 32 KiB ROM/RAM and serialises it as an ASCII Intel HEX text stream, one character per handshake. This is the encode direction of the ROM hex loader, used for save/dump back over the bridge. Output is 16-byte data records (type 00) and a final EOF record (type 01). Every line ends with CR LF.

Parameters:
BYTES_PER_LINE, 16, maximum data bytes per record (1..255).
ADDR_WIDTH, 15, memory address width. The emitted 16-bit address field is the read address zero-extended.

Ports:
clk_74a  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse that begins a dump. Ignored while busy=1.
start_addr  in  ADDR_WIDTH  first memory address to dump. Sampled on start.
length  in  16  number of bytes to dump (0..32768). Sampled on start.
read_en  out  1  memory read strobe.
read_addr  out  ADDR_WIDTH  memory read address.
read_data  in  8  memory data. Valid the cycle after read_en.
out_valid  out  1  out_data holds a character.
out_data  out  8  ASCII character.
out_ready  in  1  consumer accepts the character on a cycle where out_valid=1 and out_ready=1.
busy  out  1  a dump is in progress.
done  out  1  one-cycle pulse after the final LF is accepted.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Reset asserted mid-dump aborts immediately with no further characters.
- Hex digits are uppercase. Nibble n<10 encodes as 0x30+n; otherwise 0x37+n.
- Record format: ':' LL AAAA TT D0..Dn-1 CC CR(0x0D) LF(0x0A).
  - LL = min(BYTES_PER_LINE, remaining).
  - AAAA = address of the line's first byte.
  - CC = (0x100 - (LL + AAAA[15:8] + AAAA[7:0] + TT + sum of data bytes)) mod 256.
  - The checksum accumulates in an 8-bit register, cleared at ':'.
- FSM: IDLE -> COLON -> LEN_H -> LEN_L -> ADDR3..ADDR0 -> TYP_H -> TYP_L -> [FETCH -> DAT_H -> DAT_L]×LL -> CHK_H -> CHK_L -> CR -> LF.
  - After LF: if remaining>0, go to COLON (next data record). Otherwise go to the EOF record ":00000001FF\r\n" (same states, TT=01, LL=0), then DONE -> IDLE.
- length=0: emit only the EOF record (13 characters).
- Handshake: each emitting state asserts out_valid. The state advances only on out_valid&&out_ready. out_data is stable while stalled, and out_valid never deasserts without acceptance.
- Fetch: FETCH asserts read_en for exactly one cycle with read_addr = current address, and out_valid=0. The byte is latched on the next cycle and DAT_H is entered. Address increments modulo 2^ADDR_WIDTH; remaining and LL decrement on DAT_L acceptance.
- Wrap: start_addr+length > 2^ADDR_WIDTH wraps read_addr to 0. A line's AAAA is its wrapped start address; lines are not split at the wrap.
- busy=1 from the cycle after start until the cycle done pulses. done and busy are never high in IDLE simultaneously with a new start being accepted that cycle. A start coincident with done is ignored.
- Minimum cost per character is 1 cycle; each data byte adds 1 fetch cycle.

Test Plan:
- start_addr=0, length=3, mem[0..2]=01,02,03, out_ready=1 -> exactly ":03000000010203F7\r\n:00000001FF\r\n" (32 chars); done pulses once; busy returns 0.
- length=17, start_addr=0, mem[0x10]=AB -> first record LL=10 at address 0000; second record ":01001000AB44\r\n"; then EOF; read_en asserted exactly 17 times.
- length=0 -> ":00000001FF\r\n" only; read_en never asserted.
- length=3, out_ready held low 5 cycles while out_data=0x33 (LEN_L) -> out_data/out_valid unchanged through the stall; stream identical to the first test.
- start_addr=0x7FFF, length=2 -> reads 7FFF then 0000; record address field "7FFF"; checksum correct for the wrapped sequence.
- reset asserted mid-data-record -> outputs 0 the next edge; a subsequent start produces a complete, correct stream; a start pulsed while busy has no effect.

Source files
------------

// File: rtl/hex_record_emitter.sv
// Serialises a memory region as an ASCII Intel HEX stream, one character per handshake.
// Data records (type 00) of up to BYTES_PER_LINE bytes, then an EOF record; every line ends CR LF.
module hex_record_emitter #(
  parameter int BYTES_PER_LINE = 16,
  parameter int ADDR_WIDTH     = 15
) (
  input  logic                  clk_74a,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [15:0]           length,
  output logic                  read_en,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [7:0]            read_data,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_COLON,
    S_LEN_H,
    S_LEN_L,
    S_ADDR3,
    S_ADDR2,
    S_ADDR1,
    S_ADDR0,
    S_TYP_H,
    S_TYP_L,
    S_FETCH,
    S_DAT_H,
    S_DAT_L,
    S_CHK_H,
    S_CHK_L,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [15:0]             remaining;
  logic [7:0]              ll;
  logic [15:0]             line_addr;
  logic [7:0]              chk;
  logic [7:0]              byte_q;
  logic                    fresh;
  logic                    eof;

  logic                    accept;
  logic [7:0]              first_ll;
  logic [7:0]              chk_final;
  logic [7:0]              cur_byte;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign read_en   = (state == S_FETCH);
  assign read_addr = addr;
  assign accept    = out_valid && out_ready;
  assign chk_final = 8'h00 - chk;
  assign first_ll  = (remaining >= 16'(BYTES_PER_LINE)) ? 8'(BYTES_PER_LINE) : remaining[7:0];
  // The fetched byte is shown straight from memory on the first DAT_H cycle, then held in byte_q.
  assign cur_byte  = fresh ? read_data : byte_q;

  always_comb begin
    out_valid = 1'b0;
    case (state)
      S_COLON, S_LEN_H, S_LEN_L, S_ADDR3, S_ADDR2, S_ADDR1, S_ADDR0,
      S_TYP_H, S_TYP_L, S_DAT_H, S_DAT_L, S_CHK_H, S_CHK_L, S_CR, S_LF:
        out_valid = 1'b1;
      default:
        out_valid = 1'b0;
    endcase
  end

  always_comb begin
    out_data = 8'h00;
    case (state)
      S_COLON: out_data = 8'h3A;
      S_LEN_H: out_data = hex_char(ll[7:4]);
      S_LEN_L: out_data = hex_char(ll[3:0]);
      S_ADDR3: out_data = hex_char(line_addr[15:12]);
      S_ADDR2: out_data = hex_char(line_addr[11:8]);
      S_ADDR1: out_data = hex_char(line_addr[7:4]);
      S_ADDR0: out_data = hex_char(line_addr[3:0]);
      S_TYP_H: out_data = 8'h30;
      S_TYP_L: out_data = eof ? 8'h31 : 8'h30;
      S_DAT_H: out_data = hex_char(cur_byte[7:4]);
      S_DAT_L: out_data = hex_char(byte_q[3:0]);
      S_CHK_H: out_data = hex_char(chk_final[7:4]);
      S_CHK_L: out_data = hex_char(chk_final[3:0]);
      S_CR:    out_data = 8'h0D;
      S_LF:    out_data = 8'h0A;
      default: out_data = 8'h00;
    endcase
  end

  // Every emitting state waits for acceptance; the checksum is built as fields are accepted.
  always_ff @(posedge clk_74a or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      ll        <= '0;
      line_addr <= '0;
      chk       <= '0;
      byte_q    <= '0;
      fresh     <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr      <= start_addr;
            remaining <= length;
            eof       <= (length == 16'd0);
            busy      <= 1'b1;
            state     <= S_COLON;
          end
        end
        S_COLON: begin
          if (accept) begin
            chk <= 8'h00;
            if (eof) begin
              ll        <= 8'h00;
              line_addr <= 16'h0000;
            end else begin
              ll        <= first_ll;
              line_addr <= 16'(addr);
            end
            state <= S_LEN_H;
          end
        end
        S_LEN_H: if (accept) state <= S_LEN_L;
        S_LEN_L: begin
          if (accept) begin
            chk   <= chk + ll;
            state <= S_ADDR3;
          end
        end
        S_ADDR3: if (accept) state <= S_ADDR2;
        S_ADDR2: begin
          if (accept) begin
            chk   <= chk + line_addr[15:8];
            state <= S_ADDR1;
          end
        end
        S_ADDR1: if (accept) state <= S_ADDR0;
        S_ADDR0: begin
          if (accept) begin
            chk   <= chk + line_addr[7:0];
            state <= S_TYP_H;
          end
        end
        S_TYP_H: if (accept) state <= S_TYP_L;
        S_TYP_L: begin
          if (accept) begin
            chk   <= chk + {7'b0, eof};
            state <= (ll == 8'd0) ? S_CHK_H : S_FETCH;
          end
        end
        S_FETCH: begin
          fresh <= 1'b1;
          state <= S_DAT_H;
        end
        S_DAT_H: begin
          if (fresh) begin
            byte_q <= read_data;
            fresh  <= 1'b0;
          end
          if (accept) state <= S_DAT_L;
        end
        S_DAT_L: begin
          if (accept) begin
            chk       <= chk + byte_q;
            ll        <= ll - 8'd1;
            remaining <= remaining - 16'd1;
            addr      <= addr + ADDR_WIDTH'(1);
            state     <= (ll == 8'd1) ? S_CHK_H : S_FETCH;
          end
        end
        S_CHK_H: if (accept) state <= S_CHK_L;
        S_CHK_L: if (accept) state <= S_CR;
        S_CR:    if (accept) state <= S_LF;
        S_LF: begin
          if (accept) begin
            if (eof) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              if (remaining == 16'd0) eof <= 1'b1;
              state <= S_COLON;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_record_emitter.sv
// Scoreboard bench for hex_record_emitter: a record-level model queues expected characters and
// read addresses; a negedge monitor compares whatever the DUT presents.
module tb_hex_record_emitter;

  localparam int AW       = 15;
  localparam int MEM_SIZE = 1 << AW;
  localparam int BPL      = 16;

  logic          clk_74a    = 1'b0;
  logic          reset      = 1'b1;
  logic          start      = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [15:0]   length     = '0;
  logic          read_en;
  logic [AW-1:0] read_addr;
  logic [7:0]    read_data  = '0;
  logic          out_valid;
  logic [7:0]    out_data;
  logic          out_ready  = 1'b1;
  logic          busy;
  logic          done;

  always #5 clk_74a = ~clk_74a;

  hex_record_emitter #(.BYTES_PER_LINE(BPL), .ADDR_WIDTH(AW)) dut (
    .clk_74a    (clk_74a),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .read_en    (read_en),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  logic [7:0] mem [0:MEM_SIZE-1];

  always @(posedge clk_74a) begin
    if (read_en) read_data <= mem[read_addr];
  end

  int          checks = 0;
  int          errors = 0;
  byte unsigned exp_q[$];
  int          exp_addr_q[$];
  int          chars_acc = 0;
  int          reads_seen = 0;
  int          done_cnt = 0;
  int          ready_mode = 0;
  int          stall_cnt = 0;
  bit          stall_done = 0;
  bit          prev_stalled = 0;
  string       hexdig = "0123456789ABCDEF";
  string       eof_str = ":00000001FF";

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  task automatic push_hex(input int v);
    exp_q.push_back(hexdig[(v >> 4) & 15]);
    exp_q.push_back(hexdig[v & 15]);
  endtask

  // Reference: whole records computed from the HEX format rules, not from the DUT's state machine.
  task automatic build_expected(input int sa, input int len);
    int rem = len;
    int off = 0;
    while (rem > 0) begin
      int n   = (rem < BPL) ? rem : BPL;
      int a   = (sa + off) % MEM_SIZE;
      int sum = n + (a >> 8) + (a & 255);
      exp_q.push_back(8'h3A);
      push_hex(n);
      push_hex(a >> 8);
      push_hex(a & 255);
      push_hex(0);
      for (int i = 0; i < n; i++) begin
        int ba = (a + i) % MEM_SIZE;
        sum += mem[ba];
        push_hex(mem[ba]);
        exp_addr_q.push_back(ba);
      end
      push_hex((256 - (sum % 256)) % 256);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      rem -= n;
      off += n;
    end
    for (int i = 0; i < eof_str.len(); i++) exp_q.push_back(eof_str[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  always @(negedge clk_74a) begin
    if (!reset) begin
      if (prev_stalled) check_output("stall_hold_valid", int'(out_valid), 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_char");
        end else begin
          check_output("char", int'(out_data), int'(exp_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            chars_acc++;
          end
        end
      end
      prev_stalled = out_valid && !out_ready;
      if (read_en) begin
        reads_seen++;
        if (exp_addr_q.size() == 0) report_fail("unexpected_read");
        else check_output("read_addr", int'(read_addr), exp_addr_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        check_output("busy_low_at_done", int'(busy), 0);
      end
    end else begin
      prev_stalled = 0;
    end
  end

  // Consumer back-pressure: 0 always ready, 1 random, 2 a five-cycle stall on the first '3'.
  initial begin
    forever begin
      @(posedge clk_74a);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!stall_done && out_valid && out_data == 8'h33) begin
            if (stall_cnt < 5) begin
              out_ready = 1'b0;
              stall_cnt++;
            end else begin
              out_ready  = 1'b1;
              stall_done = 1;
            end
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic pulse_start(input int sa, input int len);
    @(posedge clk_74a);
    #1;
    start      = 1'b1;
    start_addr = AW'(sa);
    length     = 16'(len);
    @(posedge clk_74a);
    #1;
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input int sa, input int len, input int mode, input bit extra_start);
    int n0;
    int exp_chars;
    int budget;
    int cyc;
    ready_mode = mode;
    stall_cnt  = 0;
    stall_done = 0;
    chars_acc  = 0;
    reads_seen = 0;
    done_cnt   = 0;
    n0 = exp_q.size();
    build_expected(sa, len);
    exp_chars = exp_q.size() - n0;
    budget = 40 * len + 400;
    pulse_start(sa, len);
    check_output("busy_after_start", int'(busy), 1);
    if (extra_start) begin
      repeat (7) @(posedge clk_74a);
      #1;
      start      = 1'b1;
      start_addr = AW'($urandom_range(0, MEM_SIZE - 1));
      length     = 16'($urandom_range(1, 100));
      @(posedge clk_74a);
      #1;
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < budget) begin
      @(posedge clk_74a);
      cyc++;
    end
    if (done_cnt == 0) report_fail("done_timeout");
    repeat (3) @(posedge clk_74a);
    @(negedge clk_74a);
    check_output("done_pulses", done_cnt, 1);
    check_output("char_count", chars_acc, exp_chars);
    check_output("read_count", reads_seen, len);
    check_output("chars_left", exp_q.size(), 0);
    check_output("reads_left", exp_addr_q.size(), 0);
    check_output("busy_idle", int'(busy), 0);
    check_output("valid_idle", int'(out_valid), 0);
    if (mode == 2) check_output("stall_cycles", stall_cnt, 5);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_out_valid"}, int'(out_valid), 0);
    check_output({tag, "_out_data"}, int'(out_data), 0);
    check_output({tag, "_read_en"}, int'(read_en), 0);
    check_output({tag, "_read_addr"}, int'(read_addr), 0);
    check_output({tag, "_busy"}, int'(busy), 0);
    check_output({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);

    repeat (2) @(negedge clk_74a);
    check_reset_outputs("reset");
    @(posedge clk_74a);
    #1;
    reset = 1'b0;

    $display("[TB] basic 3-byte dump");
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
    apply_stimulus(0, 3, 0, 0);

    $display("[TB] 17-byte dump across two records");
    mem[16'h10] = 8'hAB;
    apply_stimulus(0, 17, 0, 0);

    $display("[TB] empty dump");
    apply_stimulus(0, 0, 0, 0);

    $display("[TB] stall on LEN_L");
    apply_stimulus(0, 3, 2, 0);

    $display("[TB] address wrap");
    apply_stimulus(MEM_SIZE - 1, 2, 0, 0);

    $display("[TB] start while busy");
    apply_stimulus(16'h0123, 40, 1, 1);

    $display("[TB] randomized dumps");
    for (int t = 0; t < 8; t++) begin
      int sa  = $urandom_range(0, MEM_SIZE - 1);
      int len = (t == 7) ? $urandom_range(200, 300) : $urandom_range(0, 50);
      apply_stimulus(sa, len, 1, 0);
    end

    $display("[TB] reset mid-record");
    ready_mode = 0;
    chars_acc  = 0;
    build_expected(100, 40);
    pulse_start(100, 40);
    cyc = 0;
    while (chars_acc < 14 && cyc < 500) begin
      @(posedge clk_74a);
      cyc++;
    end
    if (chars_acc < 14) report_fail("mid_record_timeout");
    #1;
    reset = 1'b1;
    @(negedge clk_74a);
    check_reset_outputs("abort");
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk_74a);
    #1;
    reset = 1'b0;
    apply_stimulus(200, 20, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
